// File: rtl/uart_cal_pkg.sv
// Shared types and constants for the UART calculator datapath.
// Holds ASCII codes, formatter state encoding and result widths.
package uart_cal_pkg;

  localparam int RES_W   = 33;
  localparam int NIBBLES = 9;
  localparam int MAG_W   = NIBBLES * 4;
  localparam int IDX_W   = 4;

  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SIGN  = 3'd1,
    ST_DIGIT = 3'd2,
    ST_CR    = 3'd3,
    ST_LF    = 3'd4,
    ST_DONE  = 3'd5
  } fmt_state_t;

endpackage

// File: rtl/hex2ascii.sv
// Combinational nibble to uppercase ASCII hex digit converter.
module hex2ascii
  import uart_cal_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] ascii
);

  always_comb begin
    if (nib < 4'd10) begin
      ascii = ASCII_0 + {4'h0, nib};
    end else begin
      ascii = ASCII_A + {4'h0, nib} - 8'd10;
    end
  end

endmodule

// File: rtl/res_formatter.sv
// Captures a signed ALU result and streams it as an ASCII hex line
// (optional '-', leading-zero-suppressed digits, EOL) over valid/ready.
module res_formatter
  import uart_cal_pkg::*;
#(
  parameter bit EOL_CRLF = 1'b1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             alu_done,
  input  logic [RES_W-1:0] calc_res,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             fmt_done
);

  fmt_state_t       state_q, state_d;
  logic             neg_q, neg_d;
  logic [RES_W-1:0] mag_q, mag_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [RES_W-1:0] cap_mag;
  logic [MAG_W-1:0] cap_ext;
  logic [IDX_W-1:0] cap_idx;

  logic [MAG_W-1:0] mag_ext;
  logic [3:0]       cur_nib;
  logic [7:0]       digit_ascii;
  logic             accept;

  // Magnitude and leading-nibble index of the incoming result; only used
  // when a new line is captured.
  always_comb begin
    cap_mag = calc_res[RES_W-1] ? ((~calc_res) + RES_W'(1)) : calc_res;
    cap_ext = {{(MAG_W-RES_W){1'b0}}, cap_mag};
    cap_idx = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (cap_ext[i*4 +: 4] != 4'h0) begin
        cap_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    mag_ext = {{(MAG_W-RES_W){1'b0}}, mag_q};
    cur_nib = 4'(mag_ext >> {idx_q, 2'b00});
  end

  hex2ascii u_hex2ascii (
    .nib   (cur_nib),
    .ascii (digit_ascii)
  );

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      ST_SIGN: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_MINUS;
      end
      ST_DIGIT: begin
        tx_valid = 1'b1;
        tx_data  = digit_ascii;
      end
      ST_CR: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_CR;
      end
      ST_LF: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_LF;
      end
      default: begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
      end
    endcase
    busy     = (state_q != ST_IDLE);
    fmt_done = (state_q == ST_DONE);
  end

  assign accept = tx_valid && tx_ready;

  // A new result is only taken in IDLE; strobes during a line (including
  // the DONE cycle) fall through untouched.
  always_comb begin
    state_d = state_q;
    neg_d   = neg_q;
    mag_d   = mag_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (alu_done) begin
          neg_d   = calc_res[RES_W-1];
          mag_d   = cap_mag;
          idx_d   = cap_idx;
          state_d = calc_res[RES_W-1] ? ST_SIGN : ST_DIGIT;
        end
      end
      ST_SIGN: begin
        if (accept) begin
          state_d = ST_DIGIT;
        end
      end
      ST_DIGIT: begin
        if (accept) begin
          if (idx_q == '0) begin
            state_d = EOL_CRLF ? ST_CR : ST_LF;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
      end
      ST_CR: begin
        if (accept) begin
          state_d = ST_LF;
        end
      end
      ST_LF: begin
        if (accept) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      neg_q   <= 1'b0;
      mag_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      neg_q   <= neg_d;
      mag_q   <= mag_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_res_formatter.sv
// Randomized self-checking bench for res_formatter against a string-level
// reference model of the ASCII hex line.
module tb_res_formatter;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        alu_done = 1'b0;
  logic [32:0] calc_res = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        fmt_done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  res_formatter #(.EOL_CRLF(1'b1)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .alu_done (alu_done),
    .calc_res (calc_res),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .fmt_done (fmt_done)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line: signed value printed in hex with '-' prefix, then CR LF.
  function automatic void model_line(input logic [32:0] r);
    longint v;
    longint m;
    int d;
    logic [7:0] dig[$];
    exp_q.delete();
    v = longint'(r);
    if (r[32]) v = v - (longint'(1) <<< 33);
    if (v < 0) begin
      exp_q.push_back(8'h2D);
      m = -v;
    end else begin
      m = v;
    end
    do begin
      d = int'(m % 16);
      dig.push_front(d < 10 ? 8'(48 + d) : 8'(55 + d));
      m = m / 16;
    end while (m != 0);
    foreach (dig[i]) exp_q.push_back(dig[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  task automatic run_line(input logic [32:0] r, input bit rnd, input int inj_cyc,
                          input bit inj_done, input string tag);
    logic [7:0] got_q[$];
    int cyc = 0;
    int done_cyc = -1;
    bit prev_stall = 1'b0;
    bit stall_bad = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] gv;
    model_line(r);
    alu_done = 1'b1;
    calc_res = r;
    @(posedge clk); #1;
    alu_done = 1'b0;
    chk({tag, ":busy_start"}, 64'(busy), 64'd1);
    chk({tag, ":valid_start"}, 64'(tx_valid), 64'd1);
    while (cyc < 400) begin
      if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) stall_bad = 1'b1;
      if (fmt_done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      tx_ready = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
      if (cyc == inj_cyc) begin
        alu_done = 1'b1;
        calc_res = 33'h0_0000_0005;
      end
      if (tx_valid === 1'b1 && tx_ready) got_q.push_back(tx_data);
      prev_stall = (tx_valid === 1'b1) && !tx_ready;
      prev_data  = tx_data;
      @(posedge clk); #1;
      alu_done = 1'b0;
      cyc++;
    end
    chk({tag, ":done_seen"}, 64'(done_cyc >= 0), 64'd1);
    if (!rnd) chk({tag, ":done_latency"}, 64'(done_cyc), 64'(exp_q.size()));
    chk({tag, ":stable_while_stalled"}, 64'(stall_bad), 64'd0);
    chk({tag, ":byte_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) begin
      gv = (i < got_q.size()) ? got_q[i] : 8'h00;
      chk($sformatf("%s:byte%0d", tag, i), 64'(gv), 64'(exp_q[i]));
    end
    chk({tag, ":valid_in_done"}, 64'(tx_valid), 64'd0);
    if (inj_done) begin
      alu_done = 1'b1;
      calc_res = 33'h0_0000_0007;
    end
    @(posedge clk); #1;
    alu_done = 1'b0;
    chk({tag, ":busy_end"}, 64'(busy), 64'd0);
    chk({tag, ":valid_end"}, 64'(tx_valid), 64'd0);
    chk({tag, ":done_end"}, 64'(fmt_done), 64'd0);
    if (inj_done) begin
      @(posedge clk); #1;
      chk({tag, ":done_strobe_ignored"}, 64'(busy), 64'd0);
    end
  endtask

  task automatic reset_mid_line();
    bit stray = 1'b0;
    tx_ready = 1'b1;
    alu_done = 1'b1;
    calc_res = 33'h0_1234_5678;
    @(posedge clk); #1;
    alu_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid:still_busy", 64'(busy), 64'd1);
    n_rst = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    chk("rst_mid:valid", 64'(tx_valid), 64'd0);
    chk("rst_mid:busy", 64'(busy), 64'd0);
    chk("rst_mid:fmt_done", 64'(fmt_done), 64'd0);
    chk("rst_mid:data", 64'(tx_data), 64'd0);
    for (int i = 0; i < 20; i++) begin
      if (tx_valid !== 1'b0 || fmt_done !== 1'b0) stray = 1'b1;
      @(posedge clk); #1;
    end
    chk("rst_mid:no_activity", 64'(stray), 64'd0);
    run_line(33'h0_0000_0007, 1'b0, -1, 1'b0, "after_rst");
  endtask

  initial begin
    logic [32:0] r;
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset:valid", 64'(tx_valid), 64'd0);
    chk("reset:busy", 64'(busy), 64'd0);
    chk("reset:fmt_done", 64'(fmt_done), 64'd0);
    chk("reset:data", 64'(tx_data), 64'd0);
    n_rst = 1'b1;
    @(posedge clk); #1;

    run_line(33'h0_0000_0010, 1'b0, -1, 1'b0, "x10");
    run_line(33'h0_0000_0000, 1'b0, -1, 1'b0, "zero");
    run_line(33'h1_FFFF_FFFF, 1'b0, -1, 1'b0, "minus1");
    run_line(33'h1_0000_0000, 1'b0, -1, 1'b0, "min_neg");
    run_line(33'h0_FFFF_FFFF, 1'b0, -1, 1'b0, "max_pos");
    run_line(33'h0_0000_ABCD, 1'b1, -1, 1'b0, "abcd_rnd_a");
    run_line(33'h0_0000_ABCD, 1'b1, -1, 1'b0, "abcd_rnd_b");
    run_line(33'h0_0000_0010, 1'b0, 1, 1'b1, "drop");
    reset_mid_line();

    for (int k = 0; k < 30; k++) begin
      r = {1'($urandom), 32'($urandom)};
      if ($urandom_range(0, 1) == 1) r = r >> $urandom_range(0, 32);
      if ($urandom_range(0, 2) == 0) r = ~r;
      run_line(r, 1'($urandom_range(0, 1)), -1, 1'b0, $sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
